// File: rtl/alu_pkg.sv
// Shared ALU types: add/sub opcode encoding and sequencer state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Purpose: one bits-wide carry-lookahead adder slice (a + b + cin).
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (bits) operands; cin carry-in; sum (bits) result; cout carry out of the top bit.
module carry_lookahead_adder #(
   parameter int bits = 8
) (
   input  logic [bits-1:0] a,
   input  logic [bits-1:0] b,
   input  logic            cin,
   output logic [bits-1:0] sum,
   output logic            cout
);

   logic [bits-1:0] g;
   logic [bits-1:0] p;
   logic [bits:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Each carry is built as a flat sum of generate terms gated by the
   // propagate chain below them, so no carry depends on another carry.
   always_comb begin
      logic term_c;
      logic prod;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < bits; i++) begin
         term_c = g[i];
         prod   = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            term_c = term_c | (prod & g[j]);
            prod   = prod & p[j];
         end
         c[i+1] = term_c | (prod & cin);
      end
   end

   assign sum  = p ^ c[bits-1:0];
   assign cout = c[bits];

endmodule

// File: rtl/alu_add_sequencer.sv
// Purpose: multi-precision add/sub stepping one shared BITS-wide CLA slice over WORDS slices, LSB first.
// Latency: o_valid rises WORDS cycles after the accepting edge; one slice per cycle.
// Backpressure: o_ready only in IDLE; result and flags held in DONE until i_ready; i_valid ignored while busy.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/o_ready request handshake with
//        i_op (0 add, 1 sub), i_cin (add only), i_a/i_b operands; o_valid/i_ready result handshake with
//        o_result, o_cout (sub: 1 = no borrow), o_overflow (signed), o_zero.
module alu_add_sequencer
   import alu_pkg::*;
#(
   parameter int BITS  = 8,
   parameter int WORDS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_op,
   input  logic                  i_cin,
   input  logic [BITS*WORDS-1:0] i_a,
   input  logic [BITS*WORDS-1:0] i_b,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [BITS*WORDS-1:0] o_result,
   output logic                  o_cout,
   output logic                  o_overflow,
   output logic                  o_zero
);

   localparam int W  = BITS * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_e         state;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;      // already inverted for SUB
   logic           carry_q;
   logic [CW-1:0]  cnt;

   logic [BITS-1:0] a_sl;
   logic [BITS-1:0] b_sl;
   logic [BITS-1:0] sum_sl;
   logic            cout_sl;
   logic [W-1:0]    res_next;
   logic            last_slice;

   // Slice select and result-slice merge use constant part-selects under a
   // compare on cnt, which keeps the mux shallow and the indexing in range.
   always_comb begin
      a_sl     = '0;
      b_sl     = '0;
      res_next = o_result;
      for (int i = 0; i < WORDS; i++) begin
         if (cnt == CW'(i)) begin
            a_sl = a_q[i*BITS +: BITS];
            b_sl = b_q[i*BITS +: BITS];
            res_next[i*BITS +: BITS] = sum_sl;
         end
      end
   end

   assign last_slice = (cnt == CW'(WORDS - 1));

   carry_lookahead_adder #(.bits(BITS)) u_cla (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (carry_q),
      .sum  (sum_sl),
      .cout (cout_sl)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         o_ready    <= 1'b1;
         o_valid    <= 1'b0;
         o_result   <= '0;
         o_cout     <= 1'b0;
         o_overflow <= 1'b0;
         o_zero     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_q     <= i_a;
                  // SUB is A + ~B + 1: invert B here and seed the carry with 1.
                  b_q     <= (op_e'(i_op) == OP_SUB) ? ~i_b : i_b;
                  carry_q <= (op_e'(i_op) == OP_SUB) ? 1'b1 : i_cin;
                  cnt     <= '0;
                  o_ready <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               o_result <= res_next;
               carry_q  <= cout_sl;
               if (last_slice) begin
                  o_cout     <= cout_sl;
                  // b_q already holds B' so this is the plain same-sign rule.
                  o_overflow <= (a_q[W-1] == b_q[W-1]) && (res_next[W-1] != a_q[W-1]);
                  o_zero     <= ~|res_next;
                  o_valid    <= 1'b1;
                  cnt        <= '0;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               o_valid <= 1'b0;
               o_ready <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
